alu_bcd_seq: RTL

Parametrised, multi-cycle successor to the CPU ALU. Binary operations complete in one cycle. Decimal-mode ADD/SUB walk the operand one BCD digit per cycle, with a proper per-digit carry/borrow chain. Sits between the 6502 core's operand muxing and the status register. The caller selects the operand outside the block and drives it on port a, and all flags come out registered with a start/done handshake.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/bcd_digit_step.sv | 40 ++++
 rtl/alu_bcd_seq.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential binary/BCD ALU: opcodes, FSM states
// and the status-register bit positions the flags are written into.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4;
    localparam logic [3:0] OP_ASL = 4'd5;
    localparam logic [3:0] OP_LSR = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8;
    localparam logic [3:0] OP_INC = 4'd9;
    localparam logic [3:0] OP_DEC = 4'd10;
    localparam logic [3:0] OP_CMP = 4'd11;
    localparam logic [3:0] OP_TST = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BIN  = 2'd1,
        ST_DEC  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam int SR_N = 7;
    localparam int SR_V = 6;
    localparam int SR_Z = 1;
    localparam int SR_C = 0;

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of a decimal add or subtract, with carry/borrow in and out.
// Purely combinational; the sequencer feeds it one digit per cycle.
module bcd_digit_step (
    input  logic [3:0] digit_a,
    input  logic [3:0] digit_b,
    input  logic       carry_in,
    input  logic       sub,
    output logic [3:0] digit_out,
    output logic       carry_out
);

    logic [4:0] sum_w;
    logic [4:0] diff_w;

    // Add path corrects sums above 9 by +6; subtract path corrects negative
    // differences by +10. Both wrap to 4 bits, so invalid digits just follow
    // the same arithmetic.
    always_comb begin
        sum_w  = {1'b0, digit_a} + {1'b0, digit_b} + {4'b0000, carry_in};
        diff_w = {1'b0, digit_a} - {1'b0, digit_b} - {4'b0000, carry_in};
        if (sub) begin
            if (diff_w[4]) begin
                digit_out = diff_w[3:0] + 4'd10;
                carry_out = 1'b1;
            end else begin
                digit_out = diff_w[3:0];
                carry_out = 1'b0;
            end
        end else begin
            if (sum_w > 5'd9) begin
                digit_out = sum_w[3:0] + 4'd6;
                carry_out = 1'b1;
            end else begin
                digit_out = sum_w[3:0];
                carry_out = 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_bcd_seq.sv
// Multi-cycle ALU: binary ops take one working cycle, decimal ADD/SUB walk
// the operands one BCD digit per cycle. Results and flags are registered and
// announced with a one-cycle done pulse. WIDTH must be a multiple of 4, >= 8.
module alu_bcd_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             d_mode,
    input  logic             c_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_c
);

    localparam int DIGITS = WIDTH / 4;
    localparam int KW     = $clog2(DIGITS + 1);

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic             cin_q, cin_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] ash_q, ash_d;
    logic [WIDTH-1:0] bsh_q, bsh_d;
    logic [WIDTH-1:0] dres_q, dres_d;
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             n_q, n_d, v_q, v_d, z_q, z_d, c_q, c_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   sum_w, diff_w, cmp_w;
    logic [WIDTH-1:0] bin_res;
    logic             bin_c, bin_v;
    logic [3:0]       step_digit;
    logic             step_carry;
    logic             dec_sub;

    assign dec_sub = (op_q == OP_SUB);

    bcd_digit_step u_step (
        .digit_a   (ash_q[3:0]),
        .digit_b   (bsh_q[3:0]),
        .carry_in  (carry_q),
        .sub       (dec_sub),
        .digit_out (step_digit),
        .carry_out (step_carry)
    );

    // Binary datapath on the latched operands; also supplies V for the
    // decimal ops, which is defined from the plain binary sum/difference.
    always_comb begin
        sum_w   = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
        diff_w  = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, ~cin_q};
        cmp_w   = {1'b0, a_q} - {1'b0, b_q};
        bin_res = '1;
        bin_c   = 1'b0;
        bin_v   = 1'b0;
        case (op_q)
            OP_ADD: begin
                bin_res = sum_w[WIDTH-1:0];
                bin_c   = sum_w[WIDTH];
                bin_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                bin_res = diff_w[WIDTH-1:0];
                bin_c   = ~diff_w[WIDTH];
                bin_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: bin_res = a_q & b_q;
            OP_OR:  bin_res = a_q | b_q;
            OP_EOR: bin_res = a_q ^ b_q;
            OP_ASL: begin
                bin_res = {a_q[WIDTH-2:0], 1'b0};
                bin_c   = a_q[WIDTH-1];
            end
            OP_LSR: begin
                bin_res = {1'b0, a_q[WIDTH-1:1]};
                bin_c   = a_q[0];
            end
            OP_ROL: begin
                bin_res = {a_q[WIDTH-2:0], cin_q};
                bin_c   = a_q[WIDTH-1];
            end
            OP_ROR: begin
                bin_res = {cin_q, a_q[WIDTH-1:1]};
                bin_c   = a_q[0];
            end
            OP_INC: bin_res = a_q + WIDTH'(1);
            OP_DEC: bin_res = a_q - WIDTH'(1);
            OP_CMP: begin
                bin_res = cmp_w[WIDTH-1:0];
                bin_c   = ~cmp_w[WIDTH];
            end
            OP_TST: bin_res = a_q;
            default: begin
                bin_res = '1;
                bin_c   = 1'b0;
            end
        endcase
    end

    // Sequencer: capture on start, one BIN cycle or DIGITS digit cycles plus
    // a closing cycle that publishes the decimal result, then a FIN cycle in
    // which done is high and a new start may already be accepted.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cin_d    = cin_q;
        a_d      = a_q;
        b_d      = b_q;
        ash_d    = ash_q;
        bsh_d    = bsh_q;
        dres_d   = dres_q;
        carry_d  = carry_q;
        k_d      = k_q;
        result_d = result_q;
        n_d      = n_q;
        v_d      = v_q;
        z_d      = z_q;
        c_d      = c_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                state_d = ST_IDLE;
                if (start) begin
                    op_d    = op;
                    cin_d   = c_in;
                    a_d     = a;
                    b_d     = b;
                    ash_d   = a;
                    bsh_d   = b;
                    dres_d  = '0;
                    k_d     = '0;
                    carry_d = (op == OP_SUB) ? ~c_in : c_in;
                    if (d_mode && ((op == OP_ADD) || (op == OP_SUB)))
                        state_d = ST_DEC;
                    else
                        state_d = ST_BIN;
                end
            end
            ST_BIN: begin
                result_d = bin_res;
                n_d      = bin_res[WIDTH-1];
                z_d      = (bin_res == '0);
                c_d      = bin_c;
                v_d      = bin_v;
                done_d   = 1'b1;
                state_d  = ST_FIN;
            end
            ST_DEC: begin
                if (k_q != KW'(DIGITS)) begin
                    ash_d   = ash_q >> 4;
                    bsh_d   = bsh_q >> 4;
                    dres_d  = {step_digit, dres_q[WIDTH-1:4]};
                    carry_d = step_carry;
                    k_d     = k_q + KW'(1);
                end else begin
                    result_d = dres_q;
                    n_d      = dres_q[WIDTH-1];
                    z_d      = (dres_q == '0);
                    c_d      = dec_sub ? ~carry_q : carry_q;
                    v_d      = bin_v;
                    done_d   = 1'b1;
                    state_d  = ST_FIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            cin_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            ash_q    <= '0;
            bsh_q    <= '0;
            dres_q   <= '0;
            carry_q  <= 1'b0;
            k_q      <= '0;
            result_q <= '0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cin_q    <= cin_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ash_q    <= ash_d;
            bsh_q    <= bsh_d;
            dres_q   <= dres_d;
            carry_q  <= carry_d;
            k_q      <= k_d;
            result_q <= result_d;
            n_q      <= n_d;
            v_q      <= v_d;
            z_q      <= z_d;
            c_q      <= c_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == ST_BIN) || (state_q == ST_DEC);
    assign done   = done_q;
    assign result = result_q;
    assign flag_n = n_q;
    assign flag_v = v_q;
    assign flag_z = z_q;
    assign flag_c = c_q;

endmodule
